// File: rtl/xgriscv_defines.sv
// -----------------------------------------------------------------------------
// xgriscv_defines
// Shared definitions for the run monitor: FSM state encodings and the
// instruction words that halt a run (ecall / ebreak).
// No ports (package).
// -----------------------------------------------------------------------------
package xgriscv_defines;

   // Encodings are visible on the run_monitor state output, so keep them fixed.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DONE    = 3'd2,
      ST_TIMEOUT = 3'd3,
      ST_HANG    = 3'd4
   } mon_state_e;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   // True for the two system instructions that end a run.
   function automatic logic is_halt_instr(input logic [31:0] instr);
      return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk   - clock
//   i_rstn  - asynchronous active-low reset (count -> 0)
//   i_clr   - synchronous clear, wins over i_inc
//   i_inc   - count up by one this cycle
//   o_cnt   - current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
// Watches the writeback stage of a core during a test run and decides how the
// run ended: normally (END_PC reached or ecall/ebreak retired), by exhausting
// the cycle budget (TIMEOUT) or by going too long without retiring (HANG).
// Ports:
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   run_en     - start a run from IDLE
//   clear      - synchronous return to IDLE with all counters zeroed
//   valid_w    - an instruction retires this cycle
//   pc_w       - PC of the retiring instruction
//   instr_w    - instruction word of the retiring instruction
//   cycle_cnt  - cycles spent in RUN (saturating)
//   retire_cnt - retirements seen in RUN (saturating)
//   last_pc    - PC of the most recent retirement
//   state      - FSM state code
//   done       - run ended normally (sticky until clear/reset)
//   fail       - run ended by timeout or hang (sticky until clear/reset)
// -----------------------------------------------------------------------------
module run_monitor
   import xgriscv_defines::*;
#(
   parameter int                    ADDR_SIZE     = 32,
   parameter int                    CNT_W         = 32,
   parameter logic [ADDR_SIZE-1:0]  END_PC        = ADDR_SIZE'(32'h0000_0078),
   parameter int                    MAX_CYCLES    = 10000,
   parameter int                    STALL_LIMIT   = 64,
   parameter bit                    HALT_ON_ECALL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 run_en,
   input  logic                 clear,
   input  logic                 valid_w,
   input  logic [ADDR_SIZE-1:0] pc_w,
   input  logic [31:0]          instr_w,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [ADDR_SIZE-1:0] last_pc,
   output logic [2:0]           state,
   output logic                 done,
   output logic                 fail
);

   // Limits are tested against the counter values before this cycle's
   // increment, so the terminal state and the final count land on the
   // same edge (e.g. cycle_cnt reads MAX_CYCLES in TIMEOUT).
   localparam logic [CNT_W-1:0] LP_TMO_AT  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_HANG_AT = CNT_W'(STALL_LIMIT - 1);

   mon_state_e           r_state;
   mon_state_e           w_state_next;
   logic                 r_done;
   logic                 r_fail;
   logic                 w_done_next;
   logic                 w_fail_next;
   logic [ADDR_SIZE-1:0] r_last_pc;

   logic [CNT_W-1:0]     w_cycle_cnt;
   logic [CNT_W-1:0]     w_retire_cnt;
   logic [CNT_W-1:0]     w_idle_cnt;

   logic                 w_in_run;
   logic                 w_retire;
   logic                 w_end_hit;
   logic                 w_hang_hit;
   logic                 w_tmo_hit;

   assign w_in_run = (r_state == ST_RUN);
   assign w_retire = w_in_run && valid_w;

   // A retirement resets the idle streak, so a hang can only be declared on
   // a non-retiring cycle.
   assign w_end_hit  = w_retire &&
                       ((pc_w == END_PC) || (HALT_ON_ECALL && is_halt_instr(instr_w)));
   assign w_hang_hit = w_in_run && !valid_w && (w_idle_cnt >= LP_HANG_AT);
   assign w_tmo_hit  = w_in_run && (w_cycle_cnt >= LP_TMO_AT);

   // ---------------------------------------------------------------- counters
   // Counters only move in RUN, which freezes them in the terminal states.
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_clr  (clear),
      .i_inc  (w_in_run),
      .o_cnt  (w_cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_clr  (clear),
      .i_inc  (w_retire),
      .o_cnt  (w_retire_cnt)
   );

   sat_counter #(.W(CNT_W)) u_idle_cnt (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_clr  (clear || w_retire),
      .i_inc  (w_in_run && !valid_w),
      .o_cnt  (w_idle_cnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_pc <= '0;
      end else if (clear) begin
         r_last_pc <= '0;
      end else if (w_retire) begin
         r_last_pc <= pc_w;
      end
   end

   // ---------------------------------------------------------------- FSM
   // State register; done/fail are registered alongside so they change on
   // the same edge as state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
         r_fail  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_done_next;
         r_fail  <= w_fail_next;
      end
   end

   // Next-state logic: clear beats everything, then DONE > HANG > TIMEOUT.
   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (run_en) begin
                  w_state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_end_hit) begin
                  w_state_next = ST_DONE;
               end else if (w_hang_hit) begin
                  w_state_next = ST_HANG;
               end else if (w_tmo_hit) begin
                  w_state_next = ST_TIMEOUT;
               end
            end
            ST_DONE, ST_TIMEOUT, ST_HANG: begin
               w_state_next = r_state;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state, captured by the state register.
   always_comb begin
      w_done_next = 1'b0;
      w_fail_next = 1'b0;
      case (w_state_next)
         ST_DONE:    w_done_next = 1'b1;
         ST_TIMEOUT: w_fail_next = 1'b1;
         ST_HANG:    w_fail_next = 1'b1;
         default: begin
            w_done_next = 1'b0;
            w_fail_next = 1'b0;
         end
      endcase
   end

   assign cycle_cnt  = w_cycle_cnt;
   assign retire_cnt = w_retire_cnt;
   assign last_pc    = r_last_pc;
   assign state      = r_state;
   assign done       = r_done;
   assign fail       = r_fail;

endmodule
